pc_gen_ras: RTL
===============

// Module: pc_gen_ras
// PURPOSE
//  Parametrised program-counter generator for the fetch stage, replacing the fixed 32-bit PC register.
//  Adds: valid/ready fetch handshake, stall, halt/resume FSM, prioritised trap/redirect.
//  Adds a circular return-address stack (RAS) for return prediction.
//  Feeds instruction memory and exposes the sequential PC for link-register writeback.
// PARAMETERS
//  XLEN       32  PC / address width
//  RESET_VEC  0   PC value loaded on reset (XLEN bits)
//  INC        4   sequential increment in bytes
//  RAS_DEPTH  4   return-address-stack entries, power of 2, >=2
// PORTS
//  i_clk          in   1     clock, rising edge
//  i_rst          in   1     asynchronous reset, active-low
//  i_stall        in   1     hold PC (pipeline hazard)
//  i_halt         in   1     enter HALT (pulse)
//  i_resume       in   1     leave HALT (pulse)
//  i_trap         in   1     take trap, next PC = i_trap_vec
//  i_trap_vec     in   XLEN  trap handler address
//  i_redirect     in   1     resolved branch/jump, next PC = i_redirect_pc
//  i_redirect_pc  in   XLEN  resolved target
//  i_pred_ret     in   1     predicted return: next PC = o_ras_top, pop RAS
//  i_ras_push     in   1     call detected: push i_ras_data
//  i_ras_data     in   XLEN  return address to push
//  i_ready        in   1     imem accepts current request
//  o_pc           out  XLEN  current fetch address
//  o_pc_plus_inc  out  XLEN  o_pc + INC, comb., mod 2^XLEN
//  o_valid        out  1     o_pc is a valid fetch request
//  o_ras_top      out  XLEN  top RAS entry, 0 when empty
//  o_ras_empty    out  1     RAS count == 0
//  o_ras_full     out  1     RAS count == RAS_DEPTH
// BEHAVIOUR
//  Reset (async, i_rst=0) values:
//   - o_pc=RESET_VEC, o_valid=0, state=BOOT.
//   - RAS count=0, ptr=0, entries=0, so o_ras_top=0, o_ras_empty=1, o_ras_full=0.
//  FSM:
//   - BOOT -> RUN after exactly one clock; o_valid=0 in BOOT.
//   - RUN: o_valid=1. i_halt -> HALT.
//   - HALT: o_valid=0, PC held. i_resume, i_trap or i_redirect -> RUN.
//  Next-PC priority, evaluated each edge in RUN and HALT (highest first):
//   1. i_trap: i_trap_vec.
//   2. i_redirect: i_redirect_pc.
//   3. i_pred_ret & !o_ras_empty: o_ras_top.
//   4. i_stall | !i_ready | HALT: hold o_pc.
//   5. otherwise: o_pc+INC.
//  Trap/redirect: apply regardless of i_ready/i_stall (cancel in-flight request). Latency 1 clock.
//  In BOOT: all inputs ignored except reset; o_pc stays RESET_VEC.
//  Handshake: request accepted when o_valid & i_ready. o_pc stable while o_valid & !i_ready unless trap/redirect.
//  Arithmetic: all adds unsigned, wrap modulo 2^XLEN (e.g. 0xFFFFFFFC+4 -> 0). No misalignment checking.
//  RAS: circular buffer, ptr = index of next free slot.
//   - push: write entry[ptr], ptr++. count++ saturating at RAS_DEPTH. When full, overwrites oldest.
//   - pop (i_pred_ret taken, or priority 3 path): ptr--, count--.
//   - pop when empty: no-op, and PC follows the lower-priority path.
//   - push+pop same cycle: top entry replaced by i_ras_data; ptr and count unchanged.
//   - ptr arithmetic wraps mod RAS_DEPTH.
//   - i_trap or i_redirect in the same cycle as i_pred_ret suppresses the pop. A push still occurs.
//  Reset asserted mid-operation: immediately forces all reset values, with no wait for the clock.
// TESTING
//  1. Reset release, i_ready=1 -> 1 cycle o_valid=0, pc=0, then 0,4,8,C on successive clocks with o_valid=1.
//  2. pc=0x10, i_ready=0 for 3 cycles, then i_redirect_pc=0x80 while i_ready=0 -> pc holds 0x10 for 3 cycles, then 0x80.
//  3. Same cycle i_trap (vec=0x100), i_redirect (0x40), i_pred_ret -> next pc=0x100, RAS count unchanged.
//  4. Push 0xA0,0xB0,0xC0,0xD0,0xE0 with DEPTH=4 -> full=1, top=0xE0. Then 4 pred_ret -> pc sequence E0,D0,C0,B0, then empty=1.
//  5. pred_ret with empty RAS, pc=0x20 -> pc=0x24, ptr/count unchanged; push+pop same cycle -> top=new data, count same.
//  6. pc=0xFFFFFFFC, run -> pc=0; i_halt -> o_valid=0, pc held; i_resume -> advance; i_rst low mid-run -> pc=RESET_VEC at once.

Source files
------------

// File: rtl/pc_gen_ras.sv
// Fetch-stage program-counter generator with valid/ready handshake, halt/resume
// sequencing, prioritised trap/redirect and a circular return-address stack.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued, PC pinned at RESET_VEC
// RUN   | fetching, o_valid asserted
// HALT  | fetch suspended, PC held unless trap/redirect/return steers it
module pc_gen_ras #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_halt,
    input  logic            i_resume,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_pred_ret,
    input  logic            i_ras_push,
    input  logic [XLEN-1:0] i_ras_data,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus_inc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_empty,
    output logic            o_ras_full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   ras_q [RAS_DEPTH];
    logic [XLEN-1:0]   ras_d [RAS_DEPTH];

    logic [PW-1:0]     top_idx;
    logic              active;
    logic              do_pop;
    logic              do_push;

    assign top_idx       = ptr_q - 1'b1;
    assign active        = (state_q != S_BOOT);
    assign o_ras_empty   = (cnt_q == '0);
    assign o_ras_full    = (cnt_q == CW'(RAS_DEPTH));
    assign o_ras_top     = o_ras_empty ? '0 : ras_q[top_idx];
    assign o_pc          = pc_q;
    assign o_pc_plus_inc = pc_q + XLEN'(INC);
    assign o_valid       = (state_q == S_RUN);

    // A trap or redirect cancels the predicted return, so the stack is left untouched.
    assign do_pop  = active && i_pred_ret && !o_ras_empty && !i_trap && !i_redirect;
    assign do_push = active && i_ras_push;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (i_halt) state_d = S_HALT;
            S_HALT:  if (i_resume || i_trap || i_redirect) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (active) begin
            if (i_trap)
                pc_d = i_trap_vec;
            else if (i_redirect)
                pc_d = i_redirect_pc;
            else if (do_pop)
                pc_d = o_ras_top;
            else if (i_stall || !i_ready || state_q == S_HALT)
                pc_d = pc_q;
            else
                pc_d = o_pc_plus_inc;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        for (int i = 0; i < RAS_DEPTH; i++)
            ras_d[i] = ras_q[i];
        if (do_push && do_pop) begin
            ras_d[top_idx] = i_ras_data;
        end else if (do_push) begin
            ras_d[ptr_q] = i_ras_data;
            ptr_d        = ptr_q + 1'b1;
            if (!o_ras_full)
                cnt_d = cnt_q + 1'b1;
        end else if (do_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= ras_d[i];
        end
    end

endmodule
